mem_stage: RTL

Memory-access stage sitting directly downstream of the EX/M pipeline register. It consumes the EX/M outputs and decodes the 7-bit control field. Loads and stores are issued over a single-outstanding req/ack memory port, and the stage back-pressures EX/M through `stall_out` until the access completes. It produces a registered writeback packet (valid, destination, data) for the register file.

---
 rtl/mem_stage.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage downstream of the EX/M register.
// Decodes the EX/M control field, issues loads/stores over a single
// outstanding req/ack port, stalls EX/M until the access completes, and
// produces a registered writeback packet.
// Optional feature: define MEM_ALIGN_CHECK_EN to drop misaligned half/word
// accesses and flag them on misalign_err instead of issuing them.
module mem_stage (
  input  logic        clk,
  input  logic        rst_bar,
  input  logic        valid_in,
  input  logic [6:0]  ctrl_in,
  input  logic [2:0]  dst_idx_in,
  input  logic [31:0] execute_result_in,
  input  logic [31:0] store_data_in,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [2:0]  wb_dst,
  output logic [31:0] wb_data,
  output logic        misalign_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // Byte-enable pattern for an access of the given size at the given lane.
  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   calc_be = 4'b0001 << lane;
      2'b01:   calc_be = 4'b0011 << {lane[1], 1'b0};
      default: calc_be = 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across every lane it could land in.
  function automatic logic [31:0] rep_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   rep_wdata = {4{d[7:0]}};
      2'b01:   rep_wdata = {2{d[15:0]}};
      default: rep_wdata = d;
    endcase
  endfunction

  // Pull the addressed lane out of the load word and zero/sign extend it.
  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic sext,
                                               input logic [1:0] lane, input logic [31:0] rdata);
    logic [31:0] sh;
    case (size)
      2'b00: begin
        sh = rdata >> {lane, 3'b000};
        load_extract = {{24{sext & sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh = rdata >> {lane[1], 4'b0000};
        load_extract = {{16{sext & sh[15]}}, sh[15:0]};
      end
      default: begin
        sh = rdata;
        load_extract = sh;
      end
    endcase
  endfunction

  logic [0:0]  state_r;
  logic        mem_req_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [3:0]  mem_be_r;
  logic [31:0] mem_wdata_r;
  logic        wb_valid_r;
  logic [2:0]  wb_dst_r;
  logic [31:0] wb_data_r;
  logic        misalign_err_r;

  logic        lat_load_r;
  logic        lat_rw_r;
  logic        lat_sext_r;
  logic [1:0]  lat_size_r;
  logic [1:0]  lat_lane_r;
  logic [2:0]  lat_dst_r;

  logic        reg_write_s;
  logic        mem_rd_s;
  logic        mem_wr_s;
  logic        mem_op_s;
  logic [1:0]  size_s;
  logic        sext_s;
  logic [1:0]  lane_s;
  logic        misalign_s;
  logic        issue_s;
  logic        stall_s;
  logic        ctrl_unused_s;

  // Control-field decode; bit 6 is reserved and deliberately unused.
  always_comb begin
    reg_write_s   = ctrl_in[0];
    mem_rd_s      = ctrl_in[1];
    mem_wr_s      = ctrl_in[2];
    mem_op_s      = ctrl_in[1] | ctrl_in[2];
    size_s        = ctrl_in[4:3];
    sext_s        = ctrl_in[5];
    lane_s        = execute_result_in[1:0];
    ctrl_unused_s = ctrl_in[6];
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Half needs an even address, word needs a 4-byte aligned address.
  always_comb begin
    if (size_s == 2'b01) begin
      misalign_s = lane_s[0];
    end else if (size_s[1]) begin
      misalign_s = (lane_s != 2'b00);
    end else begin
      misalign_s = 1'b0;
    end
  end
`else
  // No alignment policing: low address bits only steer lanes.
  always_comb begin
    misalign_s = 1'b0;
  end
`endif

  // A memory op is issued only from IDLE and only when it is well aligned.
  always_comb begin
    issue_s = (state_r == IDLE) & valid_in & mem_op_s & ~misalign_s;
  end

  // Hold EX/M from acceptance until the ack cycle; never stall under reset.
  always_comb begin
    stall_s = 1'b0;
    if (!rst_bar) begin
      stall_s = 1'b0;
    end else if (state_r == BUSY) begin
      stall_s = ~mem_ack;
    end else begin
      stall_s = issue_s;
    end
  end

  // Stage FSM, memory port registers and the writeback packet.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state_r        <= IDLE;
      mem_req_r      <= 1'b0;
      mem_we_r       <= 1'b0;
      mem_addr_r     <= 32'h0000_0000;
      mem_be_r       <= 4'b0000;
      mem_wdata_r    <= 32'h0000_0000;
      wb_valid_r     <= 1'b0;
      wb_dst_r       <= 3'b000;
      wb_data_r      <= 32'h0000_0000;
      misalign_err_r <= 1'b0;
      lat_load_r     <= 1'b0;
      lat_rw_r       <= 1'b0;
      lat_sext_r     <= 1'b0;
      lat_size_r     <= 2'b00;
      lat_lane_r     <= 2'b00;
      lat_dst_r      <= 3'b000;
    end else begin
      case (state_r)
        IDLE: begin
          misalign_err_r <= 1'b0;
          if (valid_in && mem_op_s && misalign_s) begin
            wb_valid_r     <= 1'b0;
            misalign_err_r <= 1'b1;
          end else if (issue_s) begin
            lat_load_r  <= mem_rd_s;
            lat_rw_r    <= reg_write_s;
            lat_sext_r  <= sext_s;
            lat_size_r  <= size_s;
            lat_lane_r  <= lane_s;
            lat_dst_r   <= dst_idx_in;
            mem_req_r   <= 1'b1;
            mem_we_r    <= mem_wr_s & ~mem_rd_s;
            mem_addr_r  <= {execute_result_in[31:2], 2'b00};
            mem_be_r    <= calc_be(size_s, lane_s);
            mem_wdata_r <= rep_wdata(size_s, store_data_in);
            wb_valid_r  <= 1'b0;
            state_r     <= BUSY;
          end else if (valid_in) begin
            wb_valid_r <= reg_write_s;
            wb_dst_r   <= dst_idx_in;
            wb_data_r  <= execute_result_in;
          end else begin
            wb_valid_r <= 1'b0;
          end
        end
        BUSY: begin
          misalign_err_r <= 1'b0;
          if (mem_ack) begin
            mem_req_r  <= 1'b0;
            state_r    <= IDLE;
            wb_valid_r <= lat_load_r & lat_rw_r;
            wb_dst_r   <= lat_dst_r;
            wb_data_r  <= load_extract(lat_size_r, lat_sext_r, lat_lane_r, mem_rdata);
          end else begin
            wb_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r        <= IDLE;
          mem_req_r      <= 1'b0;
          wb_valid_r     <= 1'b0;
          misalign_err_r <= 1'b0;
        end
      endcase
    end
  end

  assign stall_out    = stall_s;
  assign mem_req      = mem_req_r;
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_be       = mem_be_r;
  assign mem_wdata    = mem_wdata_r;
  assign wb_valid     = wb_valid_r;
  assign wb_dst       = wb_dst_r;
  assign wb_data      = wb_data_r;
  assign misalign_err = misalign_err_r;

endmodule
